ucie_debug_stream_sched: RTL
============================

// Module: ucie_debug_stream_sched
// PURPOSE
// - Round-robin scheduler that lets NUM_SRC debug producers share one 32-bit debug stream (stream_data/valid/ready/type).
// - Producers are the thermal, ML, lane-BER and error-counter taps; the sink is the controller-side debug stream consumer.
// - Owns the free-running 64-bit debug timestamp and an accepted-beat counter.
// PARAMETERS
// - NUM_SRC   8   number of producers, 2..14; ids 0..NUM_SRC-1 are carried on stream_type
// - DATA_W    32  stream/producer data width
// PORTS
// - clk               in   1                clock; all logic is single-clock
// - rst_n             in   1                asynchronous active-low reset
// - stream_enable     in   1                1 = new grants allowed
// - src_enable        in   NUM_SRC          per-producer mask; 0 = never granted
// - src_valid         in   NUM_SRC          producer i has a word
// - src_data          in   NUM_SRC*DATA_W   producer words, slice i = [i*DATA_W +: DATA_W]
// - src_ready         out  NUM_SRC          one-hot grant; a word transfers when src_valid[i]&src_ready[i]
// - stream_data       out  DATA_W           output beat
// - stream_valid      out  1                output beat valid
// - stream_ready      in   1                sink backpressure
// - stream_type       out  4                beat type: source id, or 4'hE/4'hF (timestamp hi/lo)
// - timestamp         out  64               free-running cycle counter
// - timestamp_valid   out  1                0 in reset, 1 from the first clk edge after release
// - beat_count        out  32               accepted output beats, wraps at 2^32
// BEHAVIOUR
// - Reset (async): stream_valid=0, stream_data=0, stream_type=0, src_ready=0, timestamp=0, timestamp_valid=0,
//   beat_count=0, rr_ptr=NUM_SRC-1, state=IDLE. Asserting reset mid-packet drops the packet; no partial beat resumes.
// - timestamp += 1 every cycle and wraps 2^64-1 -> 0. beat_count += 1 on each stream_valid&stream_ready.
// - slot_free = !stream_valid | stream_ready.
// - Eligible set: src_valid & src_enable. The winner is the first eligible id scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC).
// - src_ready = onehot(winner) only when stream_enable & slot_free & (no packet beats still pending) & eligible!=0.
//   src_ready is combinational from registered state; otherwise src_ready=0.
// - On a src handshake:
//   - rr_ptr <= winner; winner data latched;
//   - next cycle stream_valid=1, stream_data=src word, stream_type=winner id.
//   - Latency: 1 clk from src handshake to stream_valid.
// - Back-to-back: grant allowed in the same cycle the current last beat is accepted -> 1 word/clk at full ready.
// - Output hold: while stream_valid & !stream_ready, stream_data/stream_type are stable and no grant is made.
// - stream_enable 0: no new grants; a packet in flight finishes (all beats); stream_valid drops after the last beat is accepted.
// - src_enable change: takes effect on the next arbitration; a latched word is always delivered.
// - src_valid of the winner dropping without a handshake is a producer protocol violation; the scheduler simply re-arbitrates.
// - States: IDLE (slot empty), DATA (data beat presented), TS_HI/TS_LO (only with the feature below).
//   - IDLE->DATA on grant.
//   - DATA->DATA on accept+grant.
//   - DATA->IDLE on accept with no grant.
// CONFIGURATION
// - UCIE_DEBUG_STREAM_TS_EN defined: each grant emits a 3-beat packet.
//   - TS_HI (type 4'hE, timestamp[63:32] latched at the grant cycle), then TS_LO (4'hF, [31:0]), then DATA.
//   - Next grant only in the cycle DATA is accepted. States: grant -> TS_HI -> TS_LO -> DATA; each advances on stream_ready.
//   - beat_count counts all 3 beats.
// - Undefined: TS_HI/TS_LO states are absent; 1-beat packets only. The timestamp/timestamp_valid ports still exist and count.
// TESTING
// - Single source: src_valid[3]=1, data 32'hCAFE0003, ready=1.
//   -> src_ready[3]=1 for 1 clk; next clk stream_valid=1, stream_data=32'hCAFE0003, stream_type=3; beat_count=1.
// - Fairness: all 8 src_valid held 1, ready=1.
//   -> grant order 0,1,...,7,0; one beat per clk after the first; each id appears exactly once per 8 beats.
// - Backpressure: ready=0 for 5 clks with a beat pending.
//   -> stream_data/type stable, src_ready=0 all 5 clks; on ready=1 the beat is accepted and the next grant is made in the same cycle.
// - Masking/enable: src_enable=8'hF0, sources 0..7 valid -> only ids 4..7 granted.
//   stream_enable dropped with a beat pending -> the beat completes and no further grants.
// - TS_EN build: grant at timestamp=64'h1_0000_0005.
//   -> beats {E,32'h1},{F,32'h5},{id,data}; beat_count +3.
// - Reset mid-packet: rst_n low while stream_valid=1 -> stream_valid=0, timestamp=0 asynchronously.
//   After release timestamp_valid=1 from the first edge; rr_ptr restarts so id 0 wins first.

Source files
------------

// File: rtl/ucie_debug_stream_sched.sv
// ucie_debug_stream_sched
//   Round-robin scheduler letting NUM_SRC debug producers (thermal, ML, lane-BER and
//   error-counter taps) share one debug stream towards the controller-side consumer.
//   Also owns the free-running 64-bit debug timestamp and the accepted-beat counter.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stream_enable     1 = new grants allowed
//   src_enable        per-producer mask, 0 = never granted
//   src_valid         producer i has a word
//   src_data          producer words, slice i = [i*DATA_W +: DATA_W]
//   src_ready         one-hot grant (combinational from registered state)
//   stream_data/valid/ready/type  output stream; type = source id, 4'hE/4'hF = timestamp hi/lo
//   timestamp         free-running cycle counter
//   timestamp_valid   0 in reset, 1 from the first edge after release
//   beat_count        accepted output beats, wraps at 2^32
//
// Build option
//   UCIE_DEBUG_STREAM_TS_EN  each grant emits TS_HI, TS_LO, DATA (3 beats). Default: 1 beat.

module ucie_debug_stream_sched #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stream_enable,
  input  logic [NUM_SRC-1:0]          src_enable,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [DATA_W-1:0]           stream_data,
  output logic                        stream_valid,
  input  logic                        stream_ready,
  output logic [3:0]                  stream_type,
  output logic [63:0]                 timestamp,
  output logic                        timestamp_valid,
  output logic [31:0]                 beat_count
);

  localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PtrW-1:0] PtrInit = PtrW'(NUM_SRC - 1);

  typedef enum logic [1:0] {StIdle, StData, StTsHi, StTsLo} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     rr_ptr_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          type_q;
  logic                valid_q;
  logic [63:0]         ts_q;
  logic                ts_valid_q;
  logic [31:0]         beat_q;
`ifdef UCIE_DEBUG_STREAM_TS_EN
  logic [31:0]         ts_lo_q;
  logic [DATA_W-1:0]   word_q;
  logic [3:0]          id_q;
`endif

  logic [NUM_SRC-1:0]  eligible;
  logic [PtrW-1:0]     winner;
  logic                found;
  int unsigned         idx;
  logic                slot_free;
  logic                can_grant;
  logic                grant;
  logic                accept;
  logic [DATA_W-1:0]   win_word;

  assign eligible  = src_valid & src_enable;
  assign slot_free = !valid_q || stream_ready;
  // Timestamp beats of an open packet must drain before the next grant.
  assign can_grant = (state_q == StIdle) || (state_q == StData);
  // ts_valid_q doubles as "out of reset" so no grant is offered while rst_n is low.
  assign grant     = ts_valid_q && stream_enable && slot_free && can_grant && found;
  assign accept    = valid_q && stream_ready;
  assign win_word  = src_data[32'(winner) * DATA_W +: DATA_W];

  // First eligible id scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && eligible[PtrW'(idx)]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (grant) src_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= PtrInit;
      data_q     <= '0;
      type_q     <= '0;
      valid_q    <= 1'b0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
      beat_q     <= '0;
`ifdef UCIE_DEBUG_STREAM_TS_EN
      ts_lo_q    <= '0;
      word_q     <= '0;
      id_q       <= '0;
`endif
    end else begin
      ts_q       <= ts_q + 64'd1;
      ts_valid_q <= 1'b1;
      if (accept) beat_q <= beat_q + 32'd1;

      case (state_q)
        StIdle, StData: begin
          if (grant) begin
            rr_ptr_q <= winner;
            valid_q  <= 1'b1;
`ifdef UCIE_DEBUG_STREAM_TS_EN
            data_q   <= DATA_W'(ts_q[63:32]);
            type_q   <= 4'hE;
            ts_lo_q  <= ts_q[31:0];
            word_q   <= win_word;
            id_q     <= 4'(winner);
            state_q  <= StTsHi;
`else
            data_q   <= win_word;
            type_q   <= 4'(winner);
            state_q  <= StData;
`endif
          end else if (accept) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
`ifdef UCIE_DEBUG_STREAM_TS_EN
        StTsHi: begin
          if (stream_ready) begin
            data_q  <= DATA_W'(ts_lo_q);
            type_q  <= 4'hF;
            state_q <= StTsLo;
          end
        end
        StTsLo: begin
          if (stream_ready) begin
            data_q  <= word_q;
            type_q  <= id_q;
            state_q <= StData;
          end
        end
`endif
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stream_data     = data_q;
  assign stream_valid    = valid_q;
  assign stream_type     = type_q;
  assign timestamp       = ts_q;
  assign timestamp_valid = ts_valid_q;
  assign beat_count      = beat_q;

endmodule
